// File: rtl/nbyn_pe_gen_if.sv
// Router-facing bus of the NoC processing element: packet in, mode and destination
// rewrite controls, transformed packet out, with ready/valid on both sides.
interface nbyn_pe_gen_if #(
   parameter int X_SIZE  = 1,
   parameter int Y_SIZE  = 1,
   parameter int PCK_NUM = 7,
   parameter int ITER    = 32
);
   localparam int TW = X_SIZE + Y_SIZE + PCK_NUM + 8 * ITER;

   logic [TW-1:0]     i_data;
   logic              i_valid;
   logic              o_ready;
   logic [1:0]        mode;
   logic [X_SIZE-1:0] dest_x;
   logic [Y_SIZE-1:0] dest_y;
   logic [TW-1:0]     o_data;
   logic              o_valid;
   logic              i_ready;

   // PE side
   modport slave (
      input  i_data, i_valid, mode, dest_x, dest_y, i_ready,
      output o_ready, o_data, o_valid
   );

   // router / return-path side
   modport master (
      output i_data, i_valid, mode, dest_x, dest_y, i_ready,
      input  o_ready, o_data, o_valid
   );
endinterface

// File: rtl/nbyn_pe_gen.sv
// Parametrised NoC processing element: one transform stage feeding a
// first-word-fall-through FIFO, ready/valid on both sides.
// Optional packet statistics counters enabled by defining PE_STATS_EN.

// One payload byte lane. rev_i is the mirror byte used by the reverse mode.
module nbyn_pe_byte #(
   parameter logic [7:0] ADD_CONST = 8'h01
) (
   input  logic [1:0] mode_i,
   input  logic [7:0] fwd_i,
   input  logic [7:0] rev_i,
   output logic [7:0] byte_o
);
   // per-byte transform select
   always_comb begin
      byte_o = fwd_i;
      case (mode_i)
         2'b00:   byte_o = 8'hff - fwd_i;
         2'b01:   byte_o = fwd_i;
         2'b10:   byte_o = rev_i;
         default: byte_o = fwd_i + ADD_CONST;   // wraps mod 256
      endcase
   end
endmodule

module nbyn_pe_gen #(
   parameter int         X_SIZE    = 1,
   parameter int         Y_SIZE    = 1,
   parameter int         PCK_NUM   = 7,
   parameter int         ITER      = 32,
   parameter int         DEPTH     = 16,
   parameter logic [7:0] ADD_CONST = 8'h01
) (
   input  logic           clk,
   input  logic           rst,
   nbyn_pe_gen_if.slave   bus,
   output logic [15:0]    pkt_in_cnt,
   output logic [15:0]    pkt_out_cnt
);
   localparam int XY  = X_SIZE + Y_SIZE;
   localparam int HDR = XY + PCK_NUM;
   localparam int TW  = HDR + 8 * ITER;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int OW  = AW + 2;   // occupancy never wraps even in unreachable states

   logic                      accept, push, pop;
   logic [ITER-1:0][7:0]      pay_in, pay_out;
   logic [TW-1:0]             s1_data_d, s1_data_q;
   logic                      s1_valid_d, s1_valid_q;
   logic [TW-1:0]             mem_q [DEPTH];
   logic [AW-1:0]             wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
   logic [CW-1:0]             count_d, count_q;
   logic [OW-1:0]             occupancy;
   logic                      fifo_nonempty;

   assign pay_in = bus.i_data[TW-1:HDR];

   for (genvar k = 0; k < ITER; k++) begin : g_lane
      nbyn_pe_byte #(.ADD_CONST(ADD_CONST)) u_byte (
         .mode_i (bus.mode),
         .fwd_i  (pay_in[k]),
         .rev_i  (pay_in[ITER-1-k]),
         .byte_o (pay_out[k])
      );
   end

   // Stage never stalls: the occupancy rule reserves a FIFO slot for it,
   // so a staged packet is always written on the following edge.
   assign occupancy     = OW'(count_q) + OW'(s1_valid_q);
   assign fifo_nonempty = (count_q != '0);
   assign bus.o_ready   = !rst && (occupancy < OW'(DEPTH));
   assign bus.o_valid   = fifo_nonempty;
   assign bus.o_data    = fifo_nonempty ? mem_q[rd_ptr_q] : '0;

   assign accept = bus.i_valid && bus.o_ready;
   assign push   = s1_valid_q;
   assign pop    = fifo_nonempty && bus.i_ready;

   assign s1_valid_d = accept;
   assign s1_data_d  = accept ? {pay_out, bus.i_data[HDR-1:XY], bus.dest_y, bus.dest_x}
                              : s1_data_q;

   // next-state for FIFO pointers and count
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   // stage register and FIFO control state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; contents are don't-care once the pointers are reset
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s1_data_q;
   end

`ifdef PE_STATS_EN
   logic [15:0] in_cnt_q, out_cnt_q;

   // accepted / delivered packet counters, free-running 16-bit wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         if (accept) in_cnt_q  <= in_cnt_q + 16'd1;
         if (pop)    out_cnt_q <= out_cnt_q + 16'd1;
      end
   end

   assign pkt_in_cnt  = in_cnt_q;
   assign pkt_out_cnt = out_cnt_q;
`else
   assign pkt_in_cnt  = 16'h0;
   assign pkt_out_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_nbyn_pe_gen.sv
// Bench for nbyn_pe_gen: vector table, hand sequences for backpressure/full/reset,
// and a long randomized stream scored against a byte-array reference model.
module tb_nbyn_pe_gen;
   localparam int X = 1, Y = 1, PCK = 7, ITER = 32, DEPTH = 16;
   localparam int XY = X + Y;
   localparam int HDR = XY + PCK;
   localparam int TW = HDR + 8 * ITER;
   localparam int RW = 32 * ((TW + 31) / 32);
   localparam int NSTREAM = 70000;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pkt_in_cnt, pkt_out_cnt;

   nbyn_pe_gen_if #(.X_SIZE(X), .Y_SIZE(Y), .PCK_NUM(PCK), .ITER(ITER)) bus ();

   nbyn_pe_gen #(.X_SIZE(X), .Y_SIZE(Y), .PCK_NUM(PCK), .ITER(ITER), .DEPTH(DEPTH),
                 .ADD_CONST(8'h01)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .pkt_in_cnt  (pkt_in_cnt),
      .pkt_out_cnt (pkt_out_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int n_acc = 0, n_pop = 0;
   logic [TW-1:0] q[$];

   typedef struct {
      logic [1:0] m;
      logic [7:0] bin;
      logic [7:0] bout;
      logic [6:0] pk;
      logic       dx;
      logic       dy;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // reference: spec rules with a plain byte array
   function automatic logic [TW-1:0] model(input logic [TW-1:0] din, input logic [1:0] m,
                                           input logic [X-1:0] dx, input logic [Y-1:0] dy);
      int b[ITER];
      int o;
      logic [TW-1:0] r;
      for (int k = 0; k < ITER; k++) b[k] = int'(din[HDR + 8*k +: 8]);
      r = '0;
      r[X-1:0]      = dx;
      r[XY-1:X]     = dy;
      r[HDR-1:XY]   = din[HDR-1:XY];
      for (int k = 0; k < ITER; k++) begin
         case (m)
            2'b00:   o = 255 - b[k];
            2'b01:   o = b[k];
            2'b10:   o = b[ITER-1-k];
            default: o = (b[k] + 1) % 256;
         endcase
         r[HDR + 8*k +: 8] = 8'(o);
      end
      return r;
   endfunction

   function automatic logic [TW-1:0] fill(input logic [7:0] bv, input logic [6:0] pk,
                                          input logic [XY-1:0] hd);
      logic [TW-1:0] r;
      r = '0;
      r[XY-1:0]   = hd;
      r[HDR-1:XY] = pk;
      for (int k = 0; k < ITER; k++) r[HDR + 8*k +: 8] = bv;
      return r;
   endfunction

   task automatic rand_in();
      logic [RW-1:0] t;
      for (int w = 0; w < RW / 32; w++) t[w*32 +: 32] = $urandom;
      bus.i_data = t[TW-1:0];
      bus.mode   = 2'($urandom_range(3));
      bus.dest_x = 1'($urandom_range(1));
      bus.dest_y = 1'($urandom_range(1));
   endtask

   // one clock: entered at negedge with inputs set, sample at +1, leave at next negedge
   task automatic step();
      logic acc, pd;
      #1;
      acc = bus.i_valid && bus.o_ready;
      pd  = bus.o_valid && bus.i_ready;
      if (pd) begin
         n_pop++;
         if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL pop_unexpected: got %h want none", bus.o_data);
         end else chk("pop_data", bus.o_data, q.pop_front());
      end
      if (acc) begin
         n_acc++;
         q.push_back(model(bus.i_data, bus.mode, bus.dest_x, bus.dest_y));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int c = 0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      while ((q.size() != 0 || bus.o_valid) && c < 64) begin step(); c++; end
      chk(name, TW'(q.size()), TW'(0));
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      q.delete();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int a0, p0, cyc;
      logic [TW-1:0] e1, e2, din;

      tbl[0] = '{2'b00, 8'h0f, 8'hf0, 7'd5,   1'b0, 1'b0};
      tbl[1] = '{2'b01, 8'ha5, 8'ha5, 7'd17,  1'b1, 1'b0};
      tbl[2] = '{2'b11, 8'hff, 8'h00, 7'd127, 1'b0, 1'b1};
      tbl[3] = '{2'b11, 8'h7f, 8'h80, 7'd0,   1'b1, 1'b1};
      tbl[4] = '{2'b00, 8'h00, 8'hff, 7'd64,  1'b1, 1'b0};
      tbl[5] = '{2'b10, 8'h3c, 8'h3c, 7'd33,  1'b0, 1'b1};

      rst = 1'b1;
      bus.i_data = '0; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
      bus.mode = 2'b00; bus.dest_x = '0; bus.dest_y = '0;
      @(negedge clk); #1;
      chk("rst_o_valid", TW'(bus.o_valid), TW'(0));
      chk("rst_o_data",  bus.o_data, '0);
      chk("rst_o_ready", TW'(bus.o_ready), TW'(0));
      chk("rst_counters", TW'({pkt_in_cnt, pkt_out_cnt}), TW'(0));
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rel_o_ready", TW'(bus.o_ready), TW'(1));
      @(negedge clk);

      // table: single packets into an empty PE, 2-clock latency
      foreach (tbl[i]) begin
         bus.i_data  = fill(tbl[i].bin, tbl[i].pk, ~{tbl[i].dy, tbl[i].dx});
         bus.mode    = tbl[i].m;
         bus.dest_x  = tbl[i].dx;
         bus.dest_y  = tbl[i].dy;
         bus.i_valid = 1'b1;
         bus.i_ready = 1'b1;
         step();
         bus.i_valid = 1'b0;
         bus.mode    = ~tbl[i].m;   // late change must not touch the staged packet
         bus.dest_x  = ~tbl[i].dx;
         #1 chk($sformatf("lat1_%0d", i), TW'(bus.o_valid), TW'(0));
         step();
         #1 chk($sformatf("lat2_%0d", i), TW'(bus.o_valid), TW'(1));
         chk($sformatf("vec_%0d", i), bus.o_data,
             fill(tbl[i].bout, tbl[i].pk, {tbl[i].dy, tbl[i].dx}));
         step();
      end

      // reverse then add-wrap, held under backpressure
      bus.i_ready = 1'b0;
      din = '0;
      for (int k = 0; k < ITER; k++) din[HDR + 8*k +: 8] = 8'(k);
      din[HDR-1:XY] = 7'd9;
      e1 = din;
      for (int k = 0; k < ITER; k++) e1[HDR + 8*k +: 8] = 8'(ITER - 1 - k);
      bus.i_data = din; bus.mode = 2'b10; bus.dest_x = 1'b1; bus.dest_y = 1'b0;
      e1[XY-1:0] = 2'b01;
      bus.i_valid = 1'b1;
      step();
      bus.i_data = fill(8'hff, 7'd10, 2'b00); bus.mode = 2'b11;
      bus.dest_x = 1'b0; bus.dest_y = 1'b1;
      e2 = fill(8'h00, 7'd10, 2'b10);
      step();
      bus.i_valid = 1'b0;
      step(); step();
      #1 chk("rev_head", bus.o_data, e1);
      bus.i_ready = 1'b1;
      step();
      #1 chk("wrap_head", bus.o_data, e2);
      drain("drain_t2");

      // backpressure: exactly DEPTH accepted
      a0 = n_acc; p0 = n_pop;
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b1;
      for (int c = 0; c < 24; c++) begin rand_in(); step(); end
      chk("full_accepts", TW'(n_acc - a0), TW'(DEPTH));
      #1 chk("full_o_ready", TW'(bus.o_ready), TW'(0));
      drain("drain_full");
      chk("full_pops", TW'(n_pop - p0), TW'(DEPTH));
      #1 chk("after_drain_o_ready", TW'(bus.o_ready), TW'(1));

      // full with push+pop streaming
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin rand_in(); step(); end
      a0 = n_acc;
      bus.i_ready = 1'b1;
      rand_in();
      #1 chk("full_pop_o_ready", TW'(bus.o_ready), TW'(0));
      for (int c = 0; c < 40; c++) begin rand_in(); step(); end
      chk("stream_accepts", TW'(n_acc - a0), TW'(39));
      drain("drain_stream");

      // reset with packets in flight
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin rand_in(); step(); end
      bus.i_valid = 1'b0;
      step(); step();
      rst = 1'b1;
      #1;
      chk("midrst_o_valid", TW'(bus.o_valid), TW'(0));
      chk("midrst_o_ready", TW'(bus.o_ready), TW'(0));
      pulse_reset();
      #1;
      chk("post_rst_o_valid", TW'(bus.o_valid), TW'(0));
      chk("post_rst_o_ready", TW'(bus.o_ready), TW'(1));
      chk("post_rst_counters", TW'({pkt_in_cnt, pkt_out_cnt}), TW'(0));
      p0 = n_pop;
      bus.i_ready = 1'b1;
      bus.i_valid = 1'b1;
      rand_in();
      step();
      drain("drain_post_rst");
      chk("post_rst_pops", TW'(n_pop - p0), TW'(1));

      // long random stream, 1 packet/clk, counter wrap
      pulse_reset();
      a0 = n_acc;
      cyc = 0;
      bus.i_ready = 1'b1;
      while ((n_acc - a0) < NSTREAM && cyc < NSTREAM + 100) begin
         bus.i_valid = 1'b1;
         rand_in();
         step();
         cyc++;
      end
      chk("stream_cycles", TW'(cyc), TW'(NSTREAM));
      drain("drain_long");
`ifdef PE_STATS_EN
      chk("pkt_in_cnt",  TW'(pkt_in_cnt),  TW'(NSTREAM % 65536));
      chk("pkt_out_cnt", TW'(pkt_out_cnt), TW'(NSTREAM % 65536));
`else
      chk("pkt_in_cnt",  TW'(pkt_in_cnt),  TW'(0));
      chk("pkt_out_cnt", TW'(pkt_out_cnt), TW'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
